// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg
//   ID/EX pipeline register. Captures the decoded instruction fields and the
//   register-file operands each cycle, applies the hazard controls
//   (hold > flush > stall > load) and keeps a saturating count of bubbles
//   inserted since reset. All outputs come straight from flops; no input
//   reaches an output combinationally.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_hold                  freeze every register, counter included
//   i_flush                 replace the entering instruction with a bubble
//   i_stall                 load-use stall: insert a bubble (not a hold)
//   i_valid, i_pc ... i_mem_wr   decoded instruction from ID
//   o_valid, o_pc ... o_mem_wr   registered copies presented to EX and to
//                                the forwarding unit
//   o_bubble_cnt            bubbles inserted by flush/stall, saturating
module id_ex_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_hold,
  input  logic            i_flush,
  input  logic            i_stall,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_pc,
  input  logic [RA_W-1:0] i_rs1_addr,
  input  logic [RA_W-1:0] i_rs2_addr,
  input  logic [RA_W-1:0] i_rd_addr,
  input  logic [6:0]      i_opcode,
  input  logic [2:0]      i_funct3,
  input  logic [6:0]      i_funct7,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_reg_wr,
  input  logic            i_mem_rd,
  input  logic            i_mem_wr,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_imm,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  output logic [RA_W-1:0] o_rs1_addr,
  output logic [RA_W-1:0] o_rs2_addr,
  output logic [RA_W-1:0] o_rd_addr,
  output logic [6:0]      o_opcode,
  output logic [2:0]      o_funct3,
  output logic [6:0]      o_funct7,
  output logic            o_reg_wr,
  output logic            o_mem_rd,
  output logic            o_mem_wr,
  output logic [CNT_W-1:0] o_bubble_cnt
);

  // Stage payload. An all-zero value is a bubble: zero controls, zero
  // opcode and zero register addresses (x0 never matches in the forwarding
  // compare).
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic [RA_W-1:0] rd_addr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            reg_wr;
    logic            mem_rd;
    logic            mem_wr;
  } ex_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ex_t             ex_q, ex_d, ex_in;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            bubble_ins;

  // Incoming instruction as it would be captured on a plain load.
  always_comb begin
    ex_in          = '0;
    ex_in.valid    = 1'b1;
    ex_in.pc       = i_pc;
    ex_in.imm      = i_imm;
    ex_in.rs1_data = i_rs1_data;
    ex_in.rs2_data = i_rs2_data;
    ex_in.rs1_addr = i_rs1_addr;
    ex_in.rs2_addr = i_rs2_addr;
    ex_in.rd_addr  = i_rd_addr;
    ex_in.opcode   = i_opcode;
    ex_in.funct3   = i_funct3;
    ex_in.funct7   = i_funct7;
    // x0 is never written, so it must never be offered for forwarding.
    ex_in.reg_wr   = i_reg_wr && (i_rd_addr != '0);
    ex_in.mem_rd   = i_mem_rd;
    ex_in.mem_wr   = i_mem_wr;
  end

  // Only flush/stall count as inserted bubbles; an idle decode slot
  // (i_valid=0) also loads a bubble but is not counted.
  assign bubble_ins = !i_hold && (i_flush || i_stall);

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (!i_hold) begin
      if (i_flush || i_stall) ex_d = '0;
      else if (!i_valid)      ex_d = '0;
      else                    ex_d = ex_in;
    end
    if (bubble_ins && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_valid      = ex_q.valid;
  assign o_pc         = ex_q.pc;
  assign o_imm        = ex_q.imm;
  assign o_rs1_data   = ex_q.rs1_data;
  assign o_rs2_data   = ex_q.rs2_data;
  assign o_rs1_addr   = ex_q.rs1_addr;
  assign o_rs2_addr   = ex_q.rs2_addr;
  assign o_rd_addr    = ex_q.rd_addr;
  assign o_opcode     = ex_q.opcode;
  assign o_funct3     = ex_q.funct3;
  assign o_funct7     = ex_q.funct7;
  assign o_reg_wr     = ex_q.reg_wr;
  assign o_mem_rd     = ex_q.mem_rd;
  assign o_mem_wr     = ex_q.mem_wr;
  assign o_bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic hold, flush, stall, valid, reg_wr, mem_rd, mem_wr;
  logic [31:0] pc, imm, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;

  logic        o_valid, o_reg_wr, o_mem_rd, o_mem_wr;
  logic [31:0] o_pc, o_imm, o_rs1_data, o_rs2_data;
  logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
  logic [6:0]  o_opcode, o_funct7;
  logic [2:0]  o_funct3;
  logic [15:0] o_cnt;

  logic        s_valid, s_reg_wr, s_mem_rd, s_mem_wr;
  logic [31:0] s_pc, s_imm, s_rs1_data, s_rs2_data;
  logic [4:0]  s_rs1_addr, s_rs2_addr, s_rd_addr;
  logic [6:0]  s_opcode, s_funct7;
  logic [2:0]  s_funct3;
  logic [3:0]  s_cnt;

  id_ex_pipe_reg dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_hold(hold), .i_flush(flush), .i_stall(stall),
    .i_valid(valid), .i_pc(pc), .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
    .i_rd_addr(rd_addr), .i_opcode(opcode), .i_funct3(funct3), .i_funct7(funct7),
    .i_imm(imm), .i_rs1_data(rs1_data), .i_rs2_data(rs2_data), .i_reg_wr(reg_wr),
    .i_mem_rd(mem_rd), .i_mem_wr(mem_wr),
    .o_valid(o_valid), .o_pc(o_pc), .o_imm(o_imm), .o_rs1_data(o_rs1_data),
    .o_rs2_data(o_rs2_data), .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
    .o_rd_addr(o_rd_addr), .o_opcode(o_opcode), .o_funct3(o_funct3),
    .o_funct7(o_funct7), .o_reg_wr(o_reg_wr), .o_mem_rd(o_mem_rd),
    .o_mem_wr(o_mem_wr), .o_bubble_cnt(o_cnt));

  // Narrow-counter instance for the saturation corner.
  id_ex_pipe_reg #(.CNT_W(4)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_hold(hold), .i_flush(flush), .i_stall(stall),
    .i_valid(valid), .i_pc(pc), .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
    .i_rd_addr(rd_addr), .i_opcode(opcode), .i_funct3(funct3), .i_funct7(funct7),
    .i_imm(imm), .i_rs1_data(rs1_data), .i_rs2_data(rs2_data), .i_reg_wr(reg_wr),
    .i_mem_rd(mem_rd), .i_mem_wr(mem_wr),
    .o_valid(s_valid), .o_pc(s_pc), .o_imm(s_imm), .o_rs1_data(s_rs1_data),
    .o_rs2_data(s_rs2_data), .o_rs1_addr(s_rs1_addr), .o_rs2_addr(s_rs2_addr),
    .o_rd_addr(s_rd_addr), .o_opcode(s_opcode), .o_funct3(s_funct3),
    .o_funct7(s_funct7), .o_reg_wr(s_reg_wr), .o_mem_rd(s_mem_rd),
    .o_mem_wr(s_mem_wr), .o_bubble_cnt(s_cnt));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Reference model: what EX should hold, derived from the update rules.
  int          m_valid, m_rw, m_mr, m_mw, m_cnt, m_cnt4;
  int          m_rs1a, m_rs2a, m_rda, m_opc, m_f3, m_f7;
  logic [31:0] m_pc, m_imm, m_d1, m_d2;
  bit          m_dc;  // idle slot: data fields carry no meaning

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_cnt = 0; m_cnt4 = 0;
    m_rs1a = 0; m_rs2a = 0; m_rda = 0; m_opc = 0; m_f3 = 0; m_f7 = 0;
    m_pc = 0; m_imm = 0; m_d1 = 0; m_d2 = 0; m_dc = 0;
  endtask

  task automatic model_edge();
    if (hold) return;
    if (flush || stall) begin
      model_reset_fields();
      m_dc = 0;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end else if (!valid) begin
      model_reset_fields();
      m_dc = 1;
    end else begin
      m_valid = 1; m_pc = pc; m_imm = imm; m_d1 = rs1_data; m_d2 = rs2_data;
      m_rs1a = rs1_addr; m_rs2a = rs2_addr; m_rda = rd_addr;
      m_opc = opcode; m_f3 = funct3; m_f7 = funct7;
      m_rw = (reg_wr && rd_addr != 0) ? 1 : 0;
      m_mr = mem_rd; m_mw = mem_wr; m_dc = 0;
    end
  endtask

  task automatic model_reset_fields();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
    m_rs1a = 0; m_rs2a = 0; m_rda = 0; m_opc = 0; m_f3 = 0; m_f7 = 0;
    m_pc = 0; m_imm = 0; m_d1 = 0; m_d2 = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"},  o_valid,    m_valid[0]);
    chk({tag, ".reg_wr"}, o_reg_wr,   m_rw[0]);
    chk({tag, ".mem_rd"}, o_mem_rd,   m_mr[0]);
    chk({tag, ".mem_wr"}, o_mem_wr,   m_mw[0]);
    chk({tag, ".rs1a"},   o_rs1_addr, m_rs1a[4:0]);
    chk({tag, ".rs2a"},   o_rs2_addr, m_rs2a[4:0]);
    chk({tag, ".rda"},    o_rd_addr,  m_rda[4:0]);
    chk({tag, ".cnt"},    o_cnt,      m_cnt[15:0]);
    if (!m_dc) begin
      chk({tag, ".opc"}, o_opcode,   m_opc[6:0]);
      chk({tag, ".f3"},  o_funct3,   m_f3[2:0]);
      chk({tag, ".f7"},  o_funct7,   m_f7[6:0]);
      chk({tag, ".pc"},  o_pc,       m_pc);
      chk({tag, ".imm"}, o_imm,      m_imm);
      chk({tag, ".d1"},  o_rs1_data, m_d1);
      chk({tag, ".d2"},  o_rs2_data, m_d2);
    end
  endtask

  task automatic idle_inputs();
    hold = 0; flush = 0; stall = 0; valid = 0; reg_wr = 0; mem_rd = 0; mem_wr = 0;
    pc = 0; imm = 0; rs1_data = 0; rs2_data = 0; rs1_addr = 0; rs2_addr = 0;
    rd_addr = 0; opcode = 0; funct3 = 0; funct7 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic h, f, s, v, rw;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opc;
    logic        e_v, e_rw;
    logic [31:0] e_pc;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [6:0]  e_opc;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt[8];

  initial begin
    //           h  f  s  v rw  pc      rs1 rs2 rd  opc    | e_v e_rw e_pc  e_rs1 e_rs2 e_rd e_opc e_cnt
    vt[0] = '{0, 0, 0, 1, 1, 32'h40, 3, 4, 7, 7'h33,   1, 1, 32'h40, 3, 4, 7, 7'h33, 0}; // plain load
    vt[1] = '{0, 0, 1, 1, 1, 32'h44, 5, 6, 8, 7'h33,   0, 0, 32'h0,  0, 0, 0, 7'h00, 1}; // load-use bubble
    vt[2] = '{0, 0, 0, 1, 1, 32'h44, 5, 6, 8, 7'h33,   1, 1, 32'h44, 5, 6, 8, 7'h33, 1}; // retry captured
    vt[3] = '{1, 1, 1, 1, 1, 32'h48, 9, 9, 9, 7'h13,   1, 1, 32'h44, 5, 6, 8, 7'h33, 1}; // hold wins
    vt[4] = '{1, 1, 1, 1, 1, 32'h48, 9, 9, 9, 7'h13,   1, 1, 32'h44, 5, 6, 8, 7'h33, 1};
    vt[5] = '{1, 1, 1, 1, 1, 32'h48, 9, 9, 9, 7'h13,   1, 1, 32'h44, 5, 6, 8, 7'h33, 1};
    vt[6] = '{0, 1, 0, 1, 1, 32'h48, 9, 9, 9, 7'h13,   0, 0, 32'h0,  0, 0, 0, 7'h00, 2}; // flush on release
    vt[7] = '{0, 0, 0, 1, 1, 32'h50, 1, 2, 0, 7'h33,   1, 0, 32'h50, 1, 2, 0, 7'h33, 2}; // x0 destination

    do_reset();
    // Reset state.
    chk("rst.valid", o_valid, 1'b0);
    chk("rst.pc", o_pc, 32'h0);
    chk("rst.rd", o_rd_addr, 5'h0);
    chk("rst.reg_wr", o_reg_wr, 1'b0);
    chk("rst.cnt", o_cnt, 16'h0);

    // Table-driven directed vectors.
    for (int i = 0; i < 8; i++) begin
      hold = vt[i].h; flush = vt[i].f; stall = vt[i].s; valid = vt[i].v;
      reg_wr = vt[i].rw; pc = vt[i].pc; rs1_addr = vt[i].rs1; rs2_addr = vt[i].rs2;
      rd_addr = vt[i].rd; opcode = vt[i].opc;
      rs1_data = 32'hA; rs2_data = 32'hB;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d.valid", i), o_valid, vt[i].e_v);
      chk($sformatf("vec%0d.reg_wr", i), o_reg_wr, vt[i].e_rw);
      chk($sformatf("vec%0d.pc", i), o_pc, vt[i].e_pc);
      chk($sformatf("vec%0d.rs1", i), o_rs1_addr, vt[i].e_rs1);
      chk($sformatf("vec%0d.rs2", i), o_rs2_addr, vt[i].e_rs2);
      chk($sformatf("vec%0d.rd", i), o_rd_addr, vt[i].e_rd);
      chk($sformatf("vec%0d.opc", i), o_opcode, vt[i].e_opc);
      chk($sformatf("vec%0d.cnt", i), o_cnt, vt[i].e_cnt);
      if (vt[i].e_v) begin
        chk($sformatf("vec%0d.d1", i), o_rs1_data, 32'hA);
        chk($sformatf("vec%0d.d2", i), o_rs2_data, 32'hB);
      end
    end

    // Reset mid-stream: counter non-zero and a live instruction in EX,
    // then reset asserted between edges must clear everything at once.
    idle_inputs();
    stall = 1;
    @(posedge clk);
    @(negedge clk);
    stall = 0; valid = 1; pc = 32'h100; rd_addr = 5; reg_wr = 1;
    @(posedge clk);
    #1;
    chk("mid.pre_valid", o_valid, 1'b1);
    chk("mid.pre_pc", o_pc, 32'h100);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.valid", o_valid, 1'b0);
    chk("mid.pc", o_pc, 32'h0);
    chk("mid.rd", o_rd_addr, 5'h0);
    chk("mid.reg_wr", o_reg_wr, 1'b0);
    chk("mid.cnt", o_cnt, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Saturation on the 4-bit counter instance.
    idle_inputs();
    stall = 1; valid = 1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("sat%0d.cnt4", k), s_cnt, (k > 15) ? 4'd15 : 4'(k));
    end
    chk("sat.cnt16", o_cnt, 16'd20);
    chk("sat.valid", s_valid, 1'b0);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      hold     = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      stall    = ($urandom_range(0, 5) == 0);
      valid    = ($urandom_range(0, 3) != 0);
      reg_wr   = $urandom_range(0, 1);
      mem_rd   = $urandom_range(0, 1);
      mem_wr   = $urandom_range(0, 1);
      pc       = $urandom; imm = $urandom; rs1_data = $urandom; rs2_data = $urandom;
      rs1_addr = 5'($urandom); rs2_addr = 5'($urandom);
      rd_addr  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      opcode   = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_model($sformatf("rnd%0d", c));
      chk($sformatf("rnd%0d.cnt4", c), s_cnt, m_cnt4[3:0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
